// File: rtl/rtc_bus_arbiter_pkg.sv
// Shared types and constants for the RTC controller-port arbiter.
// Holds state encodings, requester indices and parameter defaults.
package rtc_bus_arbiter_pkg;

    localparam int NUM_REQ = 3;

    localparam int REQ_IRQ = 0;
    localparam int REQ_USR = 1;
    localparam int REQ_SWP = 2;

    localparam int ACC_HOLD_DEF   = 7;
    localparam int TIMEOUT_DEF    = 255;
    localparam int STARVE_LIM_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LATCH  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_WAIT   = 3'd3,
        ST_FIN    = 3'd4,
        ST_GAP    = 3'd5
    } state_e;

    // AND-OR pick of one 8-bit lane from a packed per-requester bus.
    function automatic logic [7:0] byte_sel(input logic [NUM_REQ*8-1:0] v,
                                            input logic [NUM_REQ-1:0]   sel);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < NUM_REQ; i++)
            r |= v[8*i +: 8] & {8{sel[i]}};
        return r;
    endfunction

endpackage

// File: rtl/rtc_bus_arbiter_if.sv
// Requester and RTC-controller signal bundle for the arbiter.
// slave = arbiter side, master = requesters plus controller side.
interface rtc_bus_arbiter_if;
    logic [2:0]  REQ;
    logic [23:0] ADDR;
    logic [2:0]  WR;
    logic [23:0] WDATA;
    logic [2:0]  GNT;
    logic [2:0]  DONE;
    logic        ERR;
    logic [7:0]  RDATA;
    logic [7:0]  Dir;
    logic        RW;
    logic [7:0]  DOUT;
    logic        Acceso;
    logic [7:0]  DIN;
    logic        FRW;

    modport slave (
        input  REQ, ADDR, WR, WDATA, DIN, FRW,
        output GNT, DONE, ERR, RDATA, Dir, RW, DOUT, Acceso
    );

    modport master (
        output REQ, ADDR, WR, WDATA, DIN, FRW,
        input  GNT, DONE, ERR, RDATA, Dir, RW, DOUT, Acceso
    );
endinterface

// File: rtl/rtc_bus_arbiter_prio_sel.sv
// Combinational winner select: fixed priority IRQ > user > sweep,
// except a starved sweep request wins outright.
module rtc_prio_sel
    import rtc_bus_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_starve,
    output logic [NUM_REQ-1:0] o_win
);

    always_comb begin
        o_win = '0;
        if (i_starve && i_req[REQ_SWP])
            o_win[REQ_SWP] = 1'b1;
        else if (i_req[REQ_IRQ])
            o_win[REQ_IRQ] = 1'b1;
        else if (i_req[REQ_USR])
            o_win[REQ_USR] = 1'b1;
        else if (i_req[REQ_SWP])
            o_win[REQ_SWP] = 1'b1;
    end

endmodule

// File: rtl/rtc_bus_arbiter.sv
// Single-owner arbiter/sequencer for the RTC Dir/Acceso/FRW port:
// latch winner, hold Acceso, wait for FRW or timeout, pulse DONE.
module rtc_bus_arbiter
    import rtc_bus_arbiter_pkg::*;
#(
    parameter int ACC_HOLD   = ACC_HOLD_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF,
    parameter int STARVE_LIM = STARVE_LIM_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    rtc_bus_arbiter_if.slave bus
);

    state_e               r_state, w_next;
    logic [3:0]           r_hold;
    logic [7:0]           r_to;
    logic [2:0]           r_starve;
    logic                 r_pend;
    logic [NUM_REQ-1:0]   r_gnt, r_done;
    logic                 r_err, r_rw, r_acc;
    logic [7:0]           r_rdata, r_dir, r_dout;

    logic [NUM_REQ-1:0]   w_win;
    logic                 w_starve, w_hold_last, w_to_last, w_frw_hit;
    logic                 w_latch_en, w_fin_go, w_cap;

    assign w_starve    = (r_starve == 3'(STARVE_LIM));
    assign w_hold_last = (r_hold == 4'(ACC_HOLD - 1));
    assign w_to_last   = (r_to == 8'(TIMEOUT - 1));
    assign w_frw_hit   = bus.FRW | r_pend;

    rtc_prio_sel u_prio (
        .i_req    (bus.REQ),
        .i_starve (w_starve),
        .o_win    (w_win)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (|bus.REQ) w_next = ST_LATCH;
            ST_LATCH:  w_next = ST_ACCESS;
            ST_ACCESS: if (w_hold_last) w_next = ST_WAIT;
            ST_WAIT:   if (w_frw_hit || w_to_last) w_next = ST_FIN;
            ST_FIN:    w_next = ST_GAP;
            ST_GAP:    w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_latch_en = 1'b0;
        w_fin_go   = 1'b0;
        w_cap      = 1'b0;
        case (r_state)
            ST_IDLE: w_latch_en = |bus.REQ;
            ST_WAIT: begin
                w_fin_go = w_frw_hit | w_to_last;
                w_cap    = w_frw_hit & ~r_rw;
            end
            default: ;
        endcase
    end

    // Counters; to_cnt tops out at TIMEOUT (<= 255), so it never wraps.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_hold   <= '0;
            r_to     <= '0;
            r_pend   <= 1'b0;
            r_starve <= '0;
        end else begin
            r_hold <= (r_state == ST_ACCESS && !w_hold_last) ? r_hold + 4'd1 : 4'd0;
            r_to   <= (r_state == ST_WAIT) ? r_to + 8'd1 : 8'd0;
            if (r_state == ST_ACCESS && bus.FRW)
                r_pend <= 1'b1;
            else if (r_state != ST_ACCESS && r_state != ST_WAIT)
                r_pend <= 1'b0;
            if (r_state == ST_FIN) begin
                if (r_gnt[REQ_SWP])
                    r_starve <= '0;
                else if (bus.REQ[REQ_SWP] && !w_starve)
                    r_starve <= r_starve + 3'd1;
            end
        end
    end

    // Controller-facing datapath; Dir/RW/DOUT only load on the IDLE->LATCH edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_gnt   <= '0;
            r_dir   <= '0;
            r_rw    <= 1'b0;
            r_dout  <= '0;
            r_acc   <= 1'b0;
            r_done  <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            if (w_latch_en) begin
                r_gnt  <= w_win;
                r_dir  <= byte_sel(bus.ADDR, w_win);
                r_rw   <= |(bus.WR & w_win);
                r_dout <= byte_sel(bus.WDATA, w_win);
            end else if (r_state == ST_FIN) begin
                r_gnt  <= '0;
            end
            r_acc  <= (w_next == ST_ACCESS);
            r_done <= w_fin_go ? r_gnt : '0;
            r_err  <= w_fin_go & ~w_frw_hit;
            if (w_cap)
                r_rdata <= bus.DIN;
        end
    end

    assign bus.GNT    = r_gnt;
    assign bus.DONE   = r_done;
    assign bus.ERR    = r_err;
    assign bus.RDATA  = r_rdata;
    assign bus.Dir    = r_dir;
    assign bus.RW     = r_rw;
    assign bus.DOUT   = r_dout;
    assign bus.Acceso = r_acc;

endmodule

// File: doc/rtc_bus_arbiter.md
Name: rtc_bus_arbiter

Overview:
Single-owner arbiter and sequencer for the RTC read/write controller port (Dir, Acceso, FRW handshake).
It shares that port between three requesters: alarm/IRQ service, user-edit write-back and the periodic display read sweep.
It latches the winning request, drives the controller's address, direction and data lines, and holds the Acceso strobe for a fixed number of cycles.
It then waits for FRW, or times out, and returns a per-requester done pulse with the read data.

Parameters:
ACC_HOLD, 7, number of cycles Acceso is held high per transaction (1..15).
TIMEOUT, 255, maximum cycles to wait for FRW after Acceso drops before aborting (1..255).
STARVE_LIM, 4, consecutive higher-priority grants after which a pending sweep request is promoted to top priority.

Ports:
CLK  in  1  system clock.
RST  in  1  reset, asynchronous, active-high.
REQ  in  3  request level per requester; bit0 = IRQ service, bit1 = user write, bit2 = read sweep; held until the matching DONE.
ADDR  in  24  requester addresses, 8 bits each, bits [8i+7:8i] for requester i.
WR  in  3  1 = write, 0 = read, per requester.
WDATA  in  24  write data, 8 bits each, same packing as ADDR.
GNT  out  3  one-hot, the current owner; 0 when idle.
DONE  out  3  one-cycle pulse to the owner at transaction end.
ERR  out  1  valid with DONE; 1 = the transaction timed out.
RDATA  out  8  read data captured from DIN; valid with DONE when the owner issued a read.
Dir  out  8  RTC controller address.
RW  out  1  controller direction, 1 = write.
DOUT  out  8  controller write data.
Acceso  out  1  controller access strobe.
DIN  in  8  controller read data.
FRW  in  1  controller finished-read/write pulse.

Behaviour:
- Reset values:
  - All outputs 0: GNT, DONE, ERR, RDATA, Dir, RW, DOUT, Acceso.
  - FSM in IDLE; hold, timeout and starvation counters cleared.
- FSM states:
  - IDLE: if any REQ bit is set, pick the winner and go to LATCH.
    - Priority is bit0 > bit1 > bit2.
    - Exception: if starve_cnt == STARVE_LIM and REQ[2]=1, requester 2 wins outright.
  - LATCH (1 cycle):
    - Register the winner's ADDR/WR/WDATA into Dir/RW/DOUT and set GNT.
    - Next cycle Acceso=1; go to ACCESS.
  - ACCESS:
    - Acceso stays high for exactly ACC_HOLD cycles, counted by hold_cnt; then Acceso=0 and go to WAIT.
    - FRW arriving during ACCESS is registered as pending.
  - WAIT:
    - On FRW, or when the pending flag is set, go to FIN with ERR=0; if RW=0, capture DIN into RDATA.
    - Otherwise increment to_cnt; if to_cnt reaches TIMEOUT, go to FIN with ERR=1 and RDATA unchanged.
  - FIN (1 cycle):
    - Pulse DONE[owner] with ERR, then clear GNT.
    - Update starve_cnt: cleared if the owner was 2; incremented (saturating at STARVE_LIM) if the owner was 0 or 1 while REQ[2]=1; otherwise unchanged.
    - Go to GAP.
  - GAP (1 cycle): turnaround, nothing issued. Return to IDLE.
- Latency: REQ seen in IDLE to Acceso rising is 2 cycles. Minimum transaction, with FRW on the first WAIT cycle, is 1 + 1 + ACC_HOLD + 1 + 1 + 1 cycles.
- Dir, RW and DOUT are stable from LATCH through FIN. Requester inputs are ignored after LATCH.
- A requester that drops REQ mid-transaction still completes and still receives DONE. There is no abort path other than timeout.
- Simultaneous requests: exactly one GNT bit is ever set. A requester that loses is served in a later IDLE evaluation.
- FRW outside ACCESS/WAIT is ignored.
- Reset mid-transaction: immediate return to IDLE, Acceso=0, no DONE issued.
- Counters: hold_cnt is 4 bits, to_cnt 8 bits, starve_cnt 3 bits. None of them wraps.

Decomposition:
- Shared package holds:
  - state encodings IDLE/LATCH/ACCESS/WAIT/FIN/GAP (3-bit);
  - requester index constants REQ_IRQ=0, REQ_USR=1, REQ_SWP=2;
  - default values for ACC_HOLD and TIMEOUT.
- One natural sub-module, rtc_prio_sel: purely combinational; maps REQ plus the starvation flag to a one-hot winner.

Test Plan:
- REQ=3'b100, read, ADDR[23:16]=8'h21, FRW pulsed 3 cycles after Acceso falls, DIN=8'h45 -> GNT=3'b100, Acceso high exactly 7 cycles, Dir=8'h21, RW=0, DONE=3'b100, RDATA=8'h45, ERR=0.
- REQ=3'b111 asserted together -> grant order: IRQ, then user, then sweep; never two GNT bits at once.
- REQ[0] held high continuously alongside REQ[2] -> after 4 IRQ grants the sweep is granted; starve_cnt returns to 0.
- User write, ADDR=8'hF0, WDATA=8'hA5, FRW never asserted -> Dir=8'hF0, RW=1, DOUT=8'hA5; DONE[1] with ERR=1 exactly 255 cycles after Acceso drops.
- FRW pulsed during the ACCESS window -> pending flag honoured; FIN is reached on the first WAIT cycle, ERR=0.
- RST asserted during WAIT -> Acceso, GNT and DONE are 0 immediately; after release, a new request is served normally.
